// File: rtl/serial_adder_pkg.sv
// Shared definitions for the multi-cycle serial add/subtract unit:
// FSM state encoding and step-counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-step unit still needs a 1-bit counter so the register is never zero-width.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// Combinational ripple slice built from single-bit full-adder cells; exposes the
// carry into its top bit so the caller can derive signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_slice #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_cell
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout     = c[W];
    assign c_msb_in = c[W-1];
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands consumed BITS_PER_CYCLE bits per clock
// through one adder_slice, with the carry registered between slices and valid/ready handshakes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
        $error("serial_adder: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [WIDTH-1:0]      sum_q, sum_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  carry_q, carry_d;
    logic                  cout_q, cout_d;
    logic                  ovf_q, ovf_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;

    logic [BITS_PER_CYCLE-1:0] slice_s;
    logic                      slice_cout;
    logic                      slice_cmsb;

    // Operands shift right each step so the active slice is always the low bits.
    adder_slice #(.W(BITS_PER_CYCLE)) u_slice (
        .a        (a_q[BITS_PER_CYCLE-1:0]),
        .b        (b_q[BITS_PER_CYCLE-1:0]),
        .cin      (carry_q),
        .s        (slice_s),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    always_comb begin
        // NOTE: every *_d defaults to its *_q first so no path through the case leaves one unassigned (no latch).
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = sub ? ~b : b;
                    carry_d    = cin ^ sub;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                a_d     = a_q >> BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                sum_d   = (sum_q >> BITS_PER_CYCLE) | (WIDTH'(slice_s) << (WIDTH - BITS_PER_CYCLE));
                carry_d = slice_cout;
                if (cnt_q == LAST) begin
                    cout_d      = slice_cout;
                    ovf_d       = slice_cout ^ slice_cmsb;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit/1-bit-per-cycle vectors with handshake, backpressure
// and reset-abort cases, then exhaustive 4-bit sweeps at 1, 2 and 4 bits per cycle.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit, 1 bit per cycle
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] a, b, sum;
    logic       cin, sub, cout, overflow;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
    );

    // 4-bit instances at 1, 2 and 4 bits per cycle, sharing operand inputs
    logic       in_valid4 [3];
    logic       out_ready4[3];
    logic       in_ready4 [3];
    logic       out_valid4[3];
    logic       busy4     [3];
    logic       cout4     [3];
    logic       ovf4      [3];
    logic [3:0] sum4      [3];
    logic [3:0] a4, b4;
    logic       cin4, sub4;

    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut4_b1 (
        .clk(clk), .rst(rst), .in_valid(in_valid4[0]), .in_ready(in_ready4[0]),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(out_valid4[0]), .out_ready(out_ready4[0]),
        .sum(sum4[0]), .cout(cout4[0]), .overflow(ovf4[0]), .busy(busy4[0])
    );
    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut4_b2 (
        .clk(clk), .rst(rst), .in_valid(in_valid4[1]), .in_ready(in_ready4[1]),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(out_valid4[1]), .out_ready(out_ready4[1]),
        .sum(sum4[1]), .cout(cout4[1]), .overflow(ovf4[1]), .busy(busy4[1])
    );
    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(4)) dut4_b4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4[2]), .in_ready(in_ready4[2]),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(out_valid4[2]), .out_ready(out_ready4[2]),
        .sum(sum4[2]), .cout(cout4[2]), .overflow(ovf4[2]), .busy(busy4[2])
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a + (sub ? ~b : b) + (cin ^ sub) in 5 bits; returns {cout, overflow, sum}.
    function automatic logic [5:0] model4(input logic [3:0] ma, input logic [3:0] mb,
                                          input logic mcin, input logic msub);
        logic [3:0] bb;
        logic [4:0] full;
        logic       ovf;
        bb   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {4'b0, mcin ^ msub};
        ovf  = (ma[3] == bb[3]) && (full[3] != ma[3]);
        return {full[4], ovf, full[3:0]};
    endfunction

    // One full 8-bit transaction with latency and handshake checks; exp = {cout, overflow, sum}.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tcin, input logic tsub, input logic [9:0] exp);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        tick();  // accept edge k
        in_valid = 1'b0;
        a = ~ta; b = ~tb; cin = ~tcin; sub = ~tsub;  // must be ignored during CALC
        check({tag, " calc in_ready/busy"}, {30'd0, in_ready, busy}, 32'b01);
        repeat (7) tick();
        check({tag, " out_valid k+7"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, " out_valid k+8"}, 32'(out_valid), 32'd1);
        check({tag, " result"}, {22'd0, cout, overflow, sum}, {22'd0, exp});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " after handshake"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
    endtask

    // One 4-bit transaction on instance idx (steps = 4 >> idx), random result backpressure.
    task automatic op4(input int idx, input logic [3:0] ta, input logic [3:0] tb,
                       input logic tcin, input logic tsub);
        int lat;
        logic [5:0] exp;
        exp = model4(ta, tb, tcin, tsub);
        a4 = ta; b4 = tb; cin4 = tcin; sub4 = tsub;
        in_valid4[idx] = 1'b1;
        tick();
        in_valid4[idx] = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid4[idx] && lat < 10);
        check($sformatf("w4 i%0d latency %h %h %b %b", idx, ta, tb, tcin, tsub), 32'(lat), 32'(4 >> idx));
        repeat ($urandom_range(0, 2)) tick();
        check($sformatf("w4 i%0d result %h %h %b %b", idx, ta, tb, tcin, tsub),
              {26'd0, cout4[idx], ovf4[idx], sum4[idx]}, {26'd0, exp});
        out_ready4[idx] = 1'b1;
        tick();
        out_ready4[idx] = 1'b0;
        check($sformatf("w4 i%0d idle", idx), {29'd0, in_ready4[idx], out_valid4[idx], busy4[idx]}, 32'b100);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid4[i]  = 1'b0;
            out_ready4[i] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;

        check("reset state", {20'd0, in_ready, out_valid, busy, sum, cout, overflow},
              {20'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});

        op8("add 5A+33",      8'h5A, 8'h33, 1'b0, 1'b0, {1'b0, 1'b1, 8'h8D});
        op8("add FF+01+1",    8'hFF, 8'h01, 1'b1, 1'b0, {1'b1, 1'b0, 8'h01});
        op8("sub 10-20",      8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 1'b0, 8'hF0});
        op8("sub 80-01",      8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
        op8("sub 00-00",      8'h00, 8'h00, 1'b0, 1'b1, {1'b1, 1'b0, 8'h00});

        // Backpressure: result held, a second operand offered but not taken until handshake.
        a = 8'h5A; b = 8'h33; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'h01; b = 8'h01;
        repeat (8) tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("backpressure hold %0d", i),
                  {21'd0, out_valid, in_ready, busy, sum}, {21'd0, 1'b1, 1'b0, 1'b1, 8'h8D});
            tick();
        end
        out_ready = 1'b1;
        tick();  // handshake edge
        out_ready = 1'b0;
        check("backpressure released", {29'd0, in_ready, out_valid, busy}, 32'b100);
        tick();  // second operand accepted here
        in_valid = 1'b0;
        check("second op accepted", {30'd0, in_ready, busy}, 32'b01);
        repeat (8) tick();
        check("second op result", {22'd0, out_valid, cout, overflow, sum},
              {22'd0, 1'b1, 1'b0, 1'b0, 8'h02});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of CALC discards the operation.
        a = 8'hC3; b = 8'h3C; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("reset mid-calc", {20'd0, in_ready, out_valid, busy, sum, cout, overflow},
              {20'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        rst = 1'b0;
        op8("after reset 5A+33", 8'h5A, 8'h33, 1'b0, 1'b0, {1'b0, 1'b1, 8'h8D});

        // Exhaustive 4-bit sweep on each slice width.
        for (int idx = 0; idx < 3; idx++)
            for (int ia = 0; ia < 16; ia++)
                for (int ib = 0; ib < 16; ib++)
                    for (int ic = 0; ic < 2; ic++)
                        for (int is = 0; is < 2; is++)
                            op4(idx, 4'(ia), 4'(ib), 1'(ic), 1'(is));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
